// File: rtl/drp_resp_pkg.sv
// Shared address map, reset constants and FSM state encoding for the DRP result responder.
package drp_resp_pkg;

  localparam logic [6:0]  RESULT_BASE    = 7'h00;
  localparam logic [6:0]  CONFIG_BASE    = 7'h40;
  localparam logic [6:0]  ALARM_THR_ADDR = 7'h4F;
  localparam int          RESULT_CNT     = 32;
  localparam int          CONFIG_CNT     = 16;
  localparam logic [15:0] ALARM_THR_RST  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } drp_state_e;

endpackage

// File: rtl/drp_result_responder_if.sv
// DRP access bus plus conversion sample port; master is the initiator/converter side.
interface drp_result_responder_if #(
  parameter int DADDR_W = 7,
  parameter int DATA_W  = 16
);
  logic               den_in;
  logic               dwe_in;
  logic [DADDR_W-1:0] daddr_in;
  logic [DATA_W-1:0]  di_in;
  logic [DATA_W-1:0]  do_out;
  logic               drdy_out;
  logic               busy_out;
  logic               sample_valid;
  logic [4:0]         sample_ch;
  logic [DATA_W-1:0]  sample_data;
  logic               eoc_out;
  logic [4:0]         channel_out;

  modport master (
    output den_in, dwe_in, daddr_in, di_in,
    output sample_valid, sample_ch, sample_data,
    input  do_out, drdy_out, busy_out, eoc_out, channel_out
  );

  modport slave (
    input  den_in, dwe_in, daddr_in, di_in,
    input  sample_valid, sample_ch, sample_data,
    output do_out, drdy_out, busy_out, eoc_out, channel_out
  );
endinterface

// File: rtl/drp_result_responder_alarm_cmp.sv
// Registered unsigned threshold compare, refreshed on each sample and held in between.
module drp_alarm_cmp #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sample_vld_i,
  input  logic [DATA_W-1:0] sample_dat_i,
  input  logic [DATA_W-1:0] thr_i,
  output logic              alarm_o
);

  logic alarm_q, alarm_d;

  always_comb begin
    alarm_d = alarm_q;
    if (sample_vld_i) alarm_d = (sample_dat_i > thr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) alarm_q <= 1'b0;
    else       alarm_q <= alarm_d;
  end

  assign alarm_o = alarm_q;

endmodule

// File: rtl/drp_result_responder.sv
// Soft XADC-style DRP responder: result/config register bank with fixed-latency drdy and EOC pulses.
// Threshold alarm is built only when DRP_RESP_ALARM_EN is defined; otherwise alarm_out is tied low.
module drp_result_responder
  import drp_resp_pkg::*;
#(
  parameter int DADDR_W  = 7,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset_in,
  drp_result_responder_if.slave   bus,
  output logic                    err_out,
  output logic                    alarm_out
);

  localparam logic [1:0]         ST_IDLE  = 2'(IDLE);
  localparam logic [1:0]         ST_WAIT  = 2'(WAIT);
  localparam logic [1:0]         ST_RESP  = 2'(RESP);
  localparam logic [DADDR_W-1:0] RES_BASE = DADDR_W'(RESULT_BASE);
  localparam logic [DADDR_W-1:0] CFG_BASE = DADDR_W'(CONFIG_BASE);
  localparam logic [3:0]         THR_IDX  = ALARM_THR_ADDR[3:0];
  localparam logic [3:0]         LAT_M1   = 4'(READ_LAT - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [DADDR_W-1:0] addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;
  logic [DATA_W-1:0]  rdat_q, rdat_d;
  logic [DATA_W-1:0]  do_q, do_d;
  logic               drdy_q, drdy_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               eoc_q, eoc_d;
  logic [4:0]         chan_q, chan_d;

  logic [DATA_W-1:0]  res_q [RESULT_CNT];
  logic [DATA_W-1:0]  cfg_q [CONFIG_CNT];

  logic               accept;
  logic               acc_is_res;
  logic               acc_is_cfg;
  logic               cap_is_cfg;
  logic               cfg_wr_en;
  logic [DATA_W-1:0]  rd_mux;

  // Both windows are naturally aligned, so decode is an upper-bit match.
  assign acc_is_res = (bus.daddr_in[DADDR_W-1:5] == RES_BASE[DADDR_W-1:5]);
  assign acc_is_cfg = (bus.daddr_in[DADDR_W-1:4] == CFG_BASE[DADDR_W-1:4]);
  assign cap_is_cfg = (addr_q[DADDR_W-1:4] == CFG_BASE[DADDR_W-1:4]);
  assign accept     = (state_q == ST_IDLE) && bus.den_in;
  assign cfg_wr_en  = (state_q == ST_RESP) && we_q && cap_is_cfg;

  // Sampled before this cycle's sample write lands, so a colliding read sees the old value.
  always_comb begin
    rd_mux = '0;
    if (acc_is_res)      rd_mux = res_q[bus.daddr_in[4:0]];
    else if (acc_is_cfg) rd_mux = cfg_q[bus.daddr_in[3:0]];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.den_in) begin
          addr_d = bus.daddr_in;
          we_d   = bus.dwe_in;
          wdat_d = bus.di_in;
          rdat_d = rd_mux;
          cnt_d  = LAT_M1;
          if (READ_LAT == 1) state_d = ST_RESP;
          else               state_d = ST_WAIT;
          if (bus.dwe_in && acc_is_res) err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
        if (bus.den_in) err_d = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (bus.den_in) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    drdy_d = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
    do_d   = do_q;
    // With single-cycle latency the capture and the response share one edge.
    if (state_d == ST_RESP) do_d = (state_q == ST_IDLE) ? rd_mux : rdat_q;
    eoc_d  = bus.sample_valid;
    chan_d = bus.sample_valid ? bus.sample_ch : chan_q;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      do_q    <= '0;
      drdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      eoc_q   <= 1'b0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      do_q    <= do_d;
      drdy_q  <= drdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      eoc_q   <= eoc_d;
      chan_q  <= chan_d;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset_in) begin
      for (int i = 0; i < RESULT_CNT; i++) res_q[i] <= '0;
      for (int i = 0; i < CONFIG_CNT; i++) cfg_q[i] <= '0;
      cfg_q[THR_IDX] <= DATA_W'(ALARM_THR_RST);
    end else begin
      if (bus.sample_valid) res_q[bus.sample_ch] <= bus.sample_data;
      if (cfg_wr_en)        cfg_q[addr_q[3:0]]   <= wdat_q;
    end
  end

  assign bus.do_out      = do_q;
  assign bus.drdy_out    = drdy_q;
  assign bus.busy_out    = busy_q;
  assign bus.eoc_out     = eoc_q;
  assign bus.channel_out = chan_q;
  assign err_out         = err_q;

`ifdef DRP_RESP_ALARM_EN
  drp_alarm_cmp #(
    .DATA_W(DATA_W)
  ) u_alarm_cmp (
    .clk_i        (CLK100MHZ),
    .rst_i        (reset_in),
    .sample_vld_i (bus.sample_valid),
    .sample_dat_i (bus.sample_data),
    .thr_i        (cfg_q[THR_IDX]),
    .alarm_o      (alarm_out)
  );
`else
  assign alarm_out = 1'b0;
`endif

endmodule

// File: tb/tb_drp_result_responder.sv
// Directed bench for drp_result_responder: DRP latency/busy, address map, errors, samples, alarm, reset.
module tb_drp_result_responder;

  localparam int RL = 2;
`ifdef DRP_RESP_ALARM_EN
  localparam logic ALARM_EN = 1'b1;
`else
  localparam logic ALARM_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic err;
  logic alarm;
  int   total;
  int   bad;
  logic [15:0] rd;
  int   ndrdy;

  drp_result_responder_if #(.DADDR_W(7), .DATA_W(16)) bus ();

  drp_result_responder #(
    .DADDR_W (7),
    .DATA_W  (16),
    .READ_LAT(RL)
  ) dut (
    .CLK100MHZ(clk),
    .reset_in (rst),
    .bus      (bus.slave),
    .err_out  (err),
    .alarm_out(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic we, input logic [6:0] addr,
                      input logic [15:0] wd, output logic [15:0] rdo);
    int lat;
    int nb;
    lat = 0;
    nb  = 0;
    rdo = '0;
    bus.den_in   = 1'b1;
    bus.dwe_in   = we;
    bus.daddr_in = addr;
    bus.di_in    = wd;
    step();
    bus.den_in       = 1'b0;
    bus.dwe_in       = 1'b0;
    bus.sample_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.busy_out) nb++;
      if (bus.drdy_out) begin
        lat = i;
        rdo = bus.do_out;
        break;
      end
      step();
    end
    chk({tag, "_lat"}, lat, RL);
    chk({tag, "_busy"}, nb, RL);
    step();
    chk({tag, "_idle"}, {bus.busy_out, bus.drdy_out}, 0);
  endtask

  task automatic sample(input logic [4:0] ch, input logic [15:0] d);
    bus.sample_valid = 1'b1;
    bus.sample_ch    = ch;
    bus.sample_data  = d;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.den_in = 0; bus.dwe_in = 0; bus.daddr_in = '0; bus.di_in = '0;
    bus.sample_valid = 0; bus.sample_ch = '0; bus.sample_data = '0;
    do_reset();
    step();
    chk("rst_do", bus.do_out, 0);
    chk("rst_drdy_busy", {bus.drdy_out, bus.busy_out}, 0);
    chk("rst_eoc_ch", {bus.eoc_out, bus.channel_out}, 0);
    chk("rst_err_alarm", {err, alarm}, 0);
    xfer("rd_thr_rst", 1'b0, 7'h4F, 16'h0, rd);
    chk("thr_rst_val", rd, 16'hFFFF);

    // 1: sample then read back
    sample(5'd2, 16'h1234);
    chk("t1_eoc", {bus.eoc_out, bus.channel_out}, {1'b1, 5'd2});
    step();
    chk("t1_eoc_off", bus.eoc_out, 0);
    xfer("t1_rd", 1'b0, 7'h02, 16'h0, rd);
    chk("t1_data", rd, 16'h1234);
    chk("t1_do_hold", bus.do_out, 16'h1234);

    bus.sample_valid = 1; bus.sample_ch = 5'd7; bus.sample_data = 16'h0707;
    step();
    bus.sample_ch = 5'd9; bus.sample_data = 16'h0909;
    chk("b2b_eoc0", {bus.eoc_out, bus.channel_out}, {1'b1, 5'd7});
    step();
    bus.sample_valid = 0;
    chk("b2b_eoc1", {bus.eoc_out, bus.channel_out}, {1'b1, 5'd9});
    step();
    chk("b2b_eoc_end", {bus.eoc_out, bus.channel_out}, {1'b0, 5'd9});
    xfer("b2b_rd", 1'b0, 7'h09, 16'h0, rd);
    chk("b2b_data", rd, 16'h0909);

    // 2: config write/read
    xfer("t2_wr", 1'b1, 7'h45, 16'hBEEF, rd);
    xfer("t2_rd", 1'b0, 7'h45, 16'h0, rd);
    chk("t2_data", rd, 16'hBEEF);
    chk("t2_err", err, 0);

    // 3: write to result space, unmapped read
    xfer("t3_wr", 1'b1, 7'h03, 16'hAAAA, rd);
    chk("t3_err", err, 1);
    xfer("t3_rd03", 1'b0, 7'h03, 16'h0, rd);
    chk("t3_data03", rd, 16'h0000);
    xfer("t3_rd60", 1'b0, 7'h60, 16'h0, rd);
    chk("t3_data60", rd, 16'h0000);

    // 4: second den while busy
    do_reset();
    chk("t4_err_clr", err, 0);
    bus.den_in = 1; bus.dwe_in = 0; bus.daddr_in = 7'h45;
    step();
    step();
    bus.den_in = 0;
    ndrdy = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.drdy_out) ndrdy++;
      step();
    end
    chk("t4_one_drdy", ndrdy, 1);
    chk("t4_err", err, 1);
    chk("t4_busy_end", bus.busy_out, 0);

    // 5: sample collides with read accept
    sample(5'd2, 16'h1234);
    bus.sample_valid = 1; bus.sample_ch = 5'd2; bus.sample_data = 16'h5555;
    xfer("t5_rd_old", 1'b0, 7'h02, 16'h0, rd);
    chk("t5_old", rd, 16'h1234);
    xfer("t5_rd_new", 1'b0, 7'h02, 16'h0, rd);
    chk("t5_new", rd, 16'h5555);

    // 6: alarm threshold
    xfer("t6_thr", 1'b1, 7'h4F, 16'h8000, rd);
    sample(5'd0, 16'h8001);
    chk("t6_a_8001", {bus.eoc_out, alarm}, {1'b1, ALARM_EN});
    step();
    chk("t6_a_hold", {bus.eoc_out, alarm}, {1'b0, ALARM_EN});
    sample(5'd0, 16'h8000);
    chk("t6_a_eq", alarm, 0);
    sample(5'd0, 16'h8001);
    chk("t6_a_8001b", alarm, ALARM_EN);
    sample(5'd0, 16'h7FFF);
    chk("t6_a_7fff", alarm, 0);
    xfer("t6_thr_rd", 1'b0, 7'h4F, 16'h0, rd);
    chk("t6_thr_val", rd, 16'h8000);

    // reset during WAIT drops the pending write
    sample(5'd1, 16'hF000);
    bus.den_in = 1; bus.dwe_in = 1; bus.daddr_in = 7'h41; bus.di_in = 16'h1111;
    step();
    bus.den_in = 0; bus.dwe_in = 0;
    chk("t6_wait_busy", {bus.busy_out, bus.drdy_out}, {1'b1, 1'b0});
    rst = 1;
    step();
    rst = 0;
    chk("t6_rst_outs", {bus.do_out, bus.drdy_out, bus.busy_out, bus.eoc_out, bus.channel_out, err, alarm}, 0);
    ndrdy = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.drdy_out) ndrdy++;
      step();
    end
    chk("t6_no_drdy", ndrdy, 0);
    xfer("t6_rd41", 1'b0, 7'h41, 16'h0, rd);
    chk("t6_no_commit", rd, 16'h0000);
    xfer("t6_rd4f", 1'b0, 7'h4F, 16'h0, rd);
    chk("t6_thr_reset", rd, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
